// File: rtl/lns_pkg.sv
// Shared types and constants for the LNS add/subtract back end.
// Interpolation is enabled by defining LNS_POST_INTERP_EN.
package lns_pkg;

    localparam int LNS_WIDTH     = 11;
    localparam int LNS_FRAC_BITS = 5;
    localparam int LNS_SEG_BITS  = 3;
    localparam int LNS_ZCUT      = 512;
    localparam int LNS_DEPTH     = 65;
    localparam int LNS_IDX_W     = 6;

    typedef logic signed [10:0] lns_t;

    localparam lns_t LNS_MIN = lns_t'(-1024);
    localparam lns_t LNS_MAX = lns_t'(1023);

    typedef enum logic {
        LNS_SUM  = 1'b0,
        LNS_DIFF = 1'b1
    } lns_path_e;

endpackage

// File: rtl/lns_postprocessor_if.sv
// Valid/ready bundle between the preprocessor, the post-processor
// and the fmadd result register.
interface lns_postprocessor_if;

    logic          in_valid;
    logic          in_ready;
    lns_pkg::lns_t in_w;
    lns_pkg::lns_t in_z;
    logic          in_zs;
    logic          out_valid;
    logic          out_ready;
    lns_pkg::lns_t out_r;
    logic          out_zero;
    logic          out_ovf;

    modport master (
        output in_valid, in_w, in_z, in_zs, out_ready,
        input  in_ready, out_valid, out_r, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, in_w, in_z, in_zs, out_ready,
        output in_ready, out_valid, out_r, out_zero, out_ovf
    );

endinterface

// File: rtl/lns_gauss_rom.sv
// Synchronous Gaussian-log tables (sb / db, step 0.25) plus fine db ROM.
// The T[idx+1] read port exists only with LNS_POST_INTERP_EN.
module lns_gauss_rom
    import lns_pkg::*;
(
    input  logic                 clk,
    input  logic                 en,
    input  lns_path_e            zs,
    input  logic [LNS_IDX_W-1:0] idx,
    input  logic [2:0]           a_fine,
    output lns_t                 t0,
`ifdef LNS_POST_INTERP_EN
    output lns_t                 t1,
`endif
    output lns_t                 tf
);

    localparam lns_t SB_TAB [LNS_DEPTH] = '{
        11'sd32, 11'sd28, 11'sd25, 11'sd22, 11'sd19, 11'sd16, 11'sd14, 11'sd12, 11'sd10, 11'sd9,
        11'sd8,  11'sd6,  11'sd5,  11'sd5,  11'sd4,  11'sd3,  11'sd3,  11'sd2,  11'sd2,  11'sd2,
        11'sd1,  11'sd1,  11'sd1,  11'sd1,  11'sd1,  11'sd1,  11'sd1,  11'sd0,  11'sd0,  11'sd0,
        11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,
        11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,
        11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0,
        11'sd0,  11'sd0,  11'sd0,  11'sd0,  11'sd0
    };

    // Entry 0 is never selected: z=0 and 0<|z|<8 take other paths.
    localparam lns_t DB_TAB [LNS_DEPTH] = '{
        11'sd0,   -11'sd77, -11'sd41, -11'sd18, 11'sd0,   11'sd15,  11'sd28,  11'sd40,  11'sd51,  11'sd61,
        11'sd71,  11'sd81,  11'sd90,  11'sd99,  11'sd108, 11'sd116, 11'sd125, 11'sd134, 11'sd142, 11'sd150,
        11'sd159, 11'sd167, 11'sd175, 11'sd183, 11'sd191, 11'sd199, 11'sd207, 11'sd216, 11'sd224, 11'sd232,
        11'sd240, 11'sd248, 11'sd256, 11'sd264, 11'sd272, 11'sd280, 11'sd288, 11'sd296, 11'sd304, 11'sd312,
        11'sd320, 11'sd328, 11'sd336, 11'sd344, 11'sd352, 11'sd360, 11'sd368, 11'sd376, 11'sd384, 11'sd392,
        11'sd400, 11'sd408, 11'sd416, 11'sd424, 11'sd432, 11'sd440, 11'sd448, 11'sd456, 11'sd464, 11'sd472,
        11'sd480, 11'sd488, 11'sd496, 11'sd504, 11'sd512
    };

    localparam lns_t FINE_TAB [8] = '{
        11'sd0, -11'sd176, -11'sd144, -11'sd125, -11'sd111, -11'sd100, -11'sd91, -11'sd84
    };

    logic [6:0] i0;
    assign i0 = {1'b0, idx};

    always_ff @(posedge clk) begin
        if (en) begin
            t0 <= (zs == LNS_DIFF) ? DB_TAB[i0] : SB_TAB[i0];
`ifdef LNS_POST_INTERP_EN
            t1 <= (zs == LNS_DIFF) ? DB_TAB[i0 + 7'd1] : SB_TAB[i0 + 7'd1];
`endif
            tf <= FINE_TAB[a_fine];
        end
    end

endmodule

// File: rtl/lns_postprocessor.sv
// LNS add/sub back end: r = w + sb/db(|z|), 3-stage valid/ready pipe.
// Define LNS_POST_INTERP_EN for linear interpolation between table steps.
module lns_postprocessor
    import lns_pkg::*;
(
    input logic                clk,
    input logic                rst,
    lns_postprocessor_if.slave bus
);

    localparam logic [10:0]        ZCUT_A  = 11'(LNS_ZCUT);
    localparam logic signed [12:0] SUM_MAX = 13'sd1023;
    localparam logic signed [12:0] SUM_MIN = -13'sd1024;

    logic        en;
    logic        v1, v2, ov;
    logic [10:0] a_in, a1, a2;
    lns_t        w1, w2;
    lns_path_e   zs1, zs2;
    logic        far1, zero1, fine1;
    logic        far2, zero2, fine2;
    lns_t        t0, tf;
    lns_t        r_q, r_sat;
    logic        zero_q, ovf_q;
    logic signed [12:0] f_tab, f, sum;
    logic        hi, lo;

    // Every stage holds together while the result register is blocked.
    assign en = !ov || bus.out_ready;
    assign a_in = bus.in_z[10] ? (~bus.in_z + 11'd1) : bus.in_z;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (en) begin
            v1 <= bus.in_valid;
            v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            w1    <= bus.in_w;
            a1    <= a_in;
            zs1   <= lns_path_e'(bus.in_zs);
            far1  <= a_in >= ZCUT_A;
            zero1 <= bus.in_zs && (a_in == '0);
            fine1 <= bus.in_zs && (a_in != '0) && (a_in < 11'd8);
            w2    <= w1;
            a2    <= a1;
            zs2   <= zs1;
            far2  <= far1;
            zero2 <= zero1;
            fine2 <= fine1;
        end
    end

`ifdef LNS_POST_INTERP_EN
    lns_t               t1;
    logic signed [11:0] dt;
    logic signed [15:0] prod;

    lns_gauss_rom u_rom (
        .clk    (clk),
        .en     (en),
        .zs     (zs1),
        .idx    (a1[8:3]),
        .a_fine (a1[2:0]),
        .t0     (t0),
        .t1     (t1),
        .tf     (tf)
    );

    assign dt    = {t1[10], t1} - {t0[10], t0};
    assign prod  = {{4{dt[11]}}, dt} * {13'd0, a2[2:0]};
    assign f_tab = {{2{t0[10]}}, t0} + 13'(prod >>> LNS_SEG_BITS);
`else
    lns_gauss_rom u_rom (
        .clk    (clk),
        .en     (en),
        .zs     (zs1),
        .idx    (a1[8:3]),
        .a_fine (a1[2:0]),
        .t0     (t0),
        .tf     (tf)
    );

    assign f_tab = {{2{t0[10]}}, t0};
`endif

    always_comb begin
        f = f_tab;
        if (far2 && zs2 == LNS_SUM) begin
            f = '0;
        end else if (far2) begin
            f = {2'b00, a2};
        end else if (fine2) begin
            f = {{2{tf[10]}}, tf};
        end
    end

    assign sum   = {{2{w2[10]}}, w2} + f;
    assign hi    = sum > SUM_MAX;
    assign lo    = sum < SUM_MIN;
    assign r_sat = hi ? LNS_MAX : (lo ? LNS_MIN : sum[10:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ov     <= 1'b0;
            r_q    <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            ov <= v2;
            if (v2) begin
                r_q    <= zero2 ? LNS_MIN : r_sat;
                zero_q <= zero2;
                ovf_q  <= !zero2 && hi;
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = ov;
    assign bus.out_r     = r_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_lns_postprocessor.sv
// Directed bench for lns_postprocessor; expectations track LNS_POST_INTERP_EN.
module tb_lns_postprocessor;
    import lns_pkg::*;

`ifdef LNS_POST_INTERP_EN
    localparam bit INTERP = 1'b1;
`else
    localparam bit INTERP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    lns_postprocessor_if bus ();

    lns_postprocessor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input int z, input logic zs);
        bus.in_valid = 1'b1;
        bus.in_w     = lns_t'(w);
        bus.in_z     = lns_t'(z);
        bus.in_zs    = zs;
    endtask

    // One isolated transaction: checks handshake, latency and result.
    task automatic send(input string tag, input int w, input int z,
                        input logic zs, input int er, input logic ez,
                        input logic eo);
        int cyc;
        drive(w, z, zs);
        chk({tag, "_rdy"}, bus.in_ready, 1);
        cyc = 0;
        do begin
            step();
            cyc++;
            bus.in_valid = 1'b0;
        end while (!bus.out_valid && cyc < 10);
        chk({tag, "_lat"}, cyc, 3);
        chk({tag, "_r"}, bus.out_r, er);
        chk({tag, "_zero"}, bus.out_zero, ez);
        chk({tag, "_ovf"}, bus.out_ovf, eo);
        step();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_w      = '0;
        bus.in_z      = '0;
        bus.in_zs     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) step();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_r", bus.out_r, 0);
        chk("rst_zero", bus.out_zero, 0);
        chk("rst_ovf", bus.out_ovf, 0);
        chk("rst_ready", bus.in_ready, 1);
        rst = 1'b0;

        send("sum0",    100,     0, 1'b0,   132, 1'b0, 1'b0);
        send("db8",     -50,    64, 1'b1,     1, 1'b0, 1'b0);
        send("dzero",   100,     0, 1'b1, -1024, 1'b1, 1'b0);
        send("ovf",    1000,     0, 1'b0,  1023, 1'b0, 1'b1);
        send("farsum",   10,  -600, 1'b0,    10, 1'b0, 1'b0);
        send("interp",    0,    -4, 1'b0, INTERP ? 30 : 32, 1'b0, 1'b0);
        send("fardif", -700,  -520, 1'b1,  -180, 1'b0, 1'b0);
        send("lowclp", -1000,    8, 1'b1, -1024, 1'b0, 1'b0);
        send("fine",    200,     3, 1'b1,    75, 1'b0, 1'b0);
        send("summid",  -20,    40, 1'b0,    -4, 1'b0, 1'b0);
        send("maxsum",    5, -1024, 1'b0,     5, 1'b0, 1'b0);
        send("maxdif", -1024, -1024, 1'b1,    0, 1'b0, 1'b0);
        send("z511",      0,   511, 1'b1, INTERP ? 511 : 504, 1'b0, 1'b0);
        send("z512",      0,   512, 1'b1,   512, 1'b0, 1'b0);
        send("d13",       0,    13, 1'b1, INTERP ? -55 : -77, 1'b0, 1'b0);
        send("s3",        0,     3, 1'b0, INTERP ? 30 : 32, 1'b0, 1'b0);

        // Fill the pipe with the result register blocked.
        bus.out_ready = 1'b0;
        drive(1, 0, 1'b0);
        chk("stl_rdyA", bus.in_ready, 1);
        step();
        drive(2, 0, 1'b0);
        step();
        drive(3, 8, 1'b1);
        step();
        drive(4, 64, 1'b1);
        chk("stl_full", bus.in_ready, 0);
        chk("stl_valid", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stl_hold_r", bus.out_r, 33);
            chk("stl_hold_rdy", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        chk("stl_A", bus.out_r, 33);
        step();
        bus.in_valid = 1'b0;
        chk("stl_B_v", bus.out_valid, 1);
        chk("stl_B", bus.out_r, 34);
        step();
        chk("stl_C_v", bus.out_valid, 1);
        chk("stl_C", bus.out_r, -74);
        step();
        chk("stl_D_v", bus.out_valid, 1);
        chk("stl_D", bus.out_r, 55);
        step();
        chk("stl_drain", bus.out_valid, 0);

        // Reset with two transactions in flight.
        drive(7, 0, 1'b0);
        step();
        drive(8, 0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_r", bus.out_r, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_rst_stale", bus.out_valid, 0);
        end

        send("post", 0, 0, 1'b0, 32, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
